// File: rtl/hsv_pkg.sv
// ============================================================
// hsv_pkg : shared types and constants for the HSV controller
// Rev 1.0
// ============================================================
`default_nettype none

package hsv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_NORM   = 3'd2,
    ST_MAXMIN = 3'd3,
    ST_DELTA  = 3'd4,
    ST_CALC   = 3'd5,
    ST_OUT    = 3'd6
  } hsv_state_t;

  localparam logic [2:0] TRI_ALL = 3'b111;
  localparam logic [2:0] TRI_OFF = 3'b000;

  localparam int PIX_W   = 32;
  localparam int R_OFS   = 64;
  localparam int G_OFS   = 32;
  localparam int B_OFS   = 0;
  localparam int PIXEL_W = 3 * PIX_W;

endpackage

`default_nettype wire

// File: rtl/hsv_ctrl_if.sv
// ============================================================
// hsv_ctrl_if : pixel-in / result-out handshake bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface hsv_ctrl_if;
  import hsv_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] pixel_in;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/hsv_wait_cnt.sv
// ============================================================
// hsv_wait_cnt : loadable down-counter with zero flag
// Rev 1.0
// ============================================================
`default_nettype none

module hsv_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/hsv_ctrl.sv
// ============================================================
// hsv_ctrl : RGB-to-HSV datapath sequencing controller (top)
// Rev 1.0
// ============================================================
`default_nettype none

module hsv_ctrl
  import hsv_pkg::*;
#(
  parameter int CALC_WAIT = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hsv_ctrl_if.slave          bus,
  output logic [PIXEL_W-1:0] dp_in,
  output logic               dp_valid,
  output logic               dp_s0,
  output logic               dp_cmax_en,
  output logic               dp_cmin_en,
  output logic               dp_delta_en,
  output logic [2:0]         dp_tri_en,
  output logic [CNT_W-1:0]   pix_count,
  output logic               busy
);

  localparam int WAIT_W = (CALC_WAIT > 0) ? $clog2(CALC_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CALC_WAIT - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_NORM   = ST_NORM;
  localparam logic [2:0] S_MAXMIN = ST_MAXMIN;
  localparam logic [2:0] S_DELTA  = ST_DELTA;
  localparam logic [2:0] S_CALC   = ST_CALC;
  localparam logic [2:0] S_OUT    = ST_OUT;

  generate
    if (CALC_WAIT < 1) begin : g_bad_calc_wait
      $error("hsv_ctrl: CALC_WAIT must be >= 1");
    end
  endgenerate

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       wait_zero;

  // Counter holds CALC_WAIT-1 on CALC entry, so CALC spans CALC_WAIT cycles.
  hsv_wait_cnt #(
    .W (WAIT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_DELTA),
    .load_val (WAIT_LOAD),
    .dec      (state == S_CALC),
    .zero     (wait_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_NORM;
      S_NORM:   state_nxt = S_MAXMIN;
      S_MAXMIN: state_nxt = S_DELTA;
      S_DELTA:  state_nxt = S_CALC;
      S_CALC:   if (wait_zero) state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dp_in     <= '0;
      pix_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && bus.in_valid) begin
        dp_in <= bus.pixel_in;
      end
      if ((state == S_OUT) && bus.out_ready) begin
        pix_count <= pix_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign dp_valid      = (state == S_LOAD) || (state == S_NORM);
  assign dp_s0         = (state == S_NORM);
  assign dp_cmax_en    = (state == S_MAXMIN);
  assign dp_cmin_en    = (state == S_MAXMIN);
  assign dp_delta_en   = (state == S_DELTA);
  assign dp_tri_en     = (state == S_OUT) ? TRI_ALL : TRI_OFF;
  assign busy          = (state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/hsv_ctrl.md
# hsv_ctrl

Sequencing controller for the RGB-to-HSV datapath. Accepts one packed {R,G,B} pixel via a valid/ready handshake and holds it stable. Drives the datapath's load/select, Cmax/Cmin/delta register enables and the H/S/V tri-state enables in a fixed multi-cycle schedule. Presents the result window to the consumer with a valid/ready handshake. Sits between the pixel source and the datapath; the datapath's H/S/V buses are read directly by the consumer while `out_valid` is high.

## Interface
- `CALC_WAIT`, default 2: cycles allowed for the combinational H/S path after the delta register loads. Must be ≥1; elaboration-time error if 0.
- `CNT_W`, default 16: width of the completed-pixel counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: source has a pixel.
- `in_ready` out 1: controller can accept a pixel; high only in IDLE.
- `pixel_in` in 96: {R[95:64], G[63:32], B[31:0]}.
- `out_valid` out 1: H/S/V on the datapath are valid and driven.
- `out_ready` in 1: consumer has taken the result.
- `dp_in` out 96: held pixel, wired to datapath `In`.
- `dp_valid` out 1: datapath RGB register load enable (`Valid`).
- `dp_s0` out 1: datapath input mux select; 0 = `In`, 1 = normalized feedback.
- `dp_cmax_en`, `dp_cmin_en`, `dp_delta_en` out 1 each: datapath register enables.
- `dp_tri_en` out 3: {H, S, V} tri-state enables.
- `pix_count` out CNT_W: completed pixels, modulo 2^CNT_W.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, LOAD, NORM, MAXMIN, DELTA, CALC, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `pixel_in` into the holding register and go to LOAD.
- LOAD: `dp_valid`=1, `dp_s0`=0 → NORM.
- NORM: `dp_valid`=1, `dp_s0`=1 → MAXMIN.
- MAXMIN: `dp_cmax_en`=`dp_cmin_en`=1 → DELTA.
- DELTA: `dp_delta_en`=1. Load the wait counter with CALC_WAIT−1 → CALC.
- CALC
  - Counter decrements each cycle.
  - Go to OUT on the cycle the counter is 0.
  - CALC therefore lasts exactly CALC_WAIT cycles.
- OUT
  - `out_valid`=1, `dp_tri_en`=3'b111.
  - Hold until `out_ready`=1.
  - On the handshake edge: `pix_count` += 1 (wraps to 0 from all-ones), go to IDLE.
- In every state other than those listed, each `dp_*` enable is 0 and `dp_tri_en`=3'b000 (bus released).
- `dp_in` is the holding register. It changes only on an accepted handshake, so it is stable from LOAD through OUT.
- `in_valid` outside IDLE is ignored; `pixel_in` is not sampled.
- `out_ready` outside OUT is ignored.
- All outputs are decoded from registered state only (Moore); no combinational input-to-output path.

## Timing
- Reset: `rst_n` low at a rising edge forces the following:
  - state = IDLE; holding register = 0; `pix_count` = 0; wait counter = 0.
  - `out_valid`=0, all `dp_*`=0, `dp_tri_en`=3'b000, `busy`=0, `in_ready`=1 from the next cycle.
  - This applies in any state, including mid-sequence and during OUT. The pixel is discarded and the count is not incremented.
- Latency: for an accept at edge k, `out_valid` rises in cycle k+5+CALC_WAIT (7 cycles for the default).
- Minimum throughput is one pixel per 7+CALC_WAIT cycles (OUT for 1 cycle, then IDLE for 1 cycle before the next accept).
- Back-pressure: `out_valid`, `dp_tri_en` and `dp_in` are held constant for as long as `out_ready` is low.

## Structure
- Shared package `hsv_pkg`:
  - state enum `hsv_state_t`;
  - constants `TRI_ALL`=3'b111 and `TRI_OFF`=3'b000;
  - pixel field offsets R/G/B (64/32/0) and width 32.
- One sub-module, `hsv_wait_cnt`: loadable down-counter with a zero flag, width $clog2(CALC_WAIT+1).
- FSM, holding register and pixel counter live in the top.

## Test plan
- Reset then single pixel:
  - Stimulus: `pixel_in`={32'd255,32'd0,32'd0}, `in_valid` pulse at edge k.
  - Required: `dp_valid`=1 in cycles k+1 and k+2 with `dp_s0`=0 then 1; `dp_cmax_en`/`dp_cmin_en` in k+3; `dp_delta_en` in k+4; `out_valid` and `dp_tri_en`=111 at k+7.
  - With `out_ready`=1: `pix_count`=1 and back to IDLE.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles in OUT; drive a new `pixel_in`={1,2,3} with `in_valid`=1.
  - Required: `dp_in` stays {255,0,0}, `in_ready`=0, `out_valid` stays 1; the new pixel is accepted only after return to IDLE.
- Back-to-back pixels:
  - Stimulus: `in_valid` held high, `out_ready` held high, 4 pixels.
  - Required: accepts 9 cycles apart; `pix_count`=4.
- Reset mid-op:
  - Stimulus: `rst_n`=0 for 1 cycle while in MAXMIN, and separately while in OUT.
  - Required: next cycle IDLE, all `dp_*`=0, `pix_count` unchanged from 0 / not incremented.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 pixels.
  - Required: `pix_count` goes 15→0→1.
- Parameter sweep:
  - Stimulus: CALC_WAIT=1 and 5.
  - Required: `out_valid` rises at k+6 and k+10 respectively.
